// File: rtl/fpu_add_scheduler.sv
// Round-robin scheduler sharing one combinational half-precision adder among NUM_REQ requesters.
// Three cycles per op minimum (accept, execute, respond); the response is held until the owner accepts it.
module fpu_add_scheduler #(
  parameter int FLOAT_WIDTH = 16,
  parameter int NUM_REQ     = 2,
  parameter int TAG_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_op,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*FLOAT_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*TAG_W-1:0]       req_tag,
  output logic [FLOAT_WIDTH-1:0]         add_float1,
  output logic [FLOAT_WIDTH-1:0]         add_float2,
  output logic                           add_subtract,
  input  logic [FLOAT_WIDTH-1:0]         add_sum,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [FLOAT_WIDTH-1:0]         resp_sum,
  output logic [TAG_W-1:0]               resp_tag,
  output logic                           resp_special,
  output logic                           busy,
  output logic [CNT_W-1:0]               op_count
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state;
  logic [OWN_W-1:0]       ptr;
  logic [OWN_W-1:0]       owner;
  logic [OWN_W-1:0]       win;
  logic [OWN_W-1:0]       cand;
  logic                   found;
  logic [FLOAT_WIDTH-1:0] a_q;
  logic [FLOAT_WIDTH-1:0] b_q;
  logic                   op_q;
  logic [TAG_W-1:0]       tag_q;
  int                     idx;

  // Search from the priority pointer upward, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = OWN_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state == IDLE && found) req_ready[win] = 1'b1;
    if (state == RESP) resp_valid[owner] = 1'b1;
  end

  assign add_float1   = (state == IDLE) ? '0   : a_q;
  assign add_float2   = (state == IDLE) ? '0   : b_q;
  assign add_subtract = (state == IDLE) ? 1'b0 : op_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      tag_q        <= '0;
      resp_sum     <= '0;
      resp_tag     <= '0;
      resp_special <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_q   <= req_a[win*FLOAT_WIDTH +: FLOAT_WIDTH];
            b_q   <= req_b[win*FLOAT_WIDTH +: FLOAT_WIDTH];
            op_q  <= req_op[win];
            tag_q <= req_tag[win*TAG_W +: TAG_W];
            owner <= win;
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_sum     <= add_sum;
          resp_tag     <= tag_q;
          resp_special <= &add_sum[14:10];
          state        <= RESP;
        end
        RESP: begin
          // Ready from any requester other than the owner is ignored.
          if (resp_ready[owner]) begin
            ptr      <= (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            op_count <= op_count + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
